// File: rtl/prio_req_encoder_if.sv
// ---------------------------------------------------------------------------
// prio_req_encoder_if
// Request/grant bundle between request sources, the priority encoder and
// the consumer that services one index at a time.
//   i       : request lines, one per index                (master -> slave)
//   ein     : enable-in; 0 forces every output inactive    (master -> slave)
//   ack     : consumer accepts the presented index y      (master -> slave)
//   y       : winning index, 0 when gs = 0                 (slave -> master)
//   gs      : group select / valid                         (slave -> master)
//   eout    : enabled and nothing pending                  (slave -> master)
//   pending : current pending register, for debug          (slave -> master)
// ---------------------------------------------------------------------------
interface prio_req_encoder_if #(
    parameter int N = 8
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] i;
    logic         ein;
    logic         ack;
    logic [W-1:0] y;
    logic         gs;
    logic         eout;
    logic [N-1:0] pending;

    // Request/consumer side.
    modport master (
        output i,
        output ein,
        output ack,
        input  y,
        input  gs,
        input  eout,
        input  pending
    );

    // Encoder side.
    modport slave (
        input  i,
        input  ein,
        input  ack,
        output y,
        output gs,
        output eout,
        output pending
    );
endinterface

// File: rtl/prio_req_encoder.sv
// ---------------------------------------------------------------------------
// prio_req_encoder
// Clocked N-way priority encoder with Ein/GS/Eout cascade semantics.
// Requests are captured into a pending register (latched until acknowledged
// when STICKY=1, mirrored from the inputs when STICKY=0). The winning index
// is presented on y with gs=1; an ack while gs=1 and ein=1 retires it.
// Priority is fixed (highest index wins, RR=0) or round-robin (RR=1), where
// the index just served becomes the lowest priority.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prio_req_encoder_if.slave (i, ein, ack in; y, gs, eout, pending out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module prio_req_encoder #(
    parameter int N      = 8,
    parameter int STICKY = 1,
    parameter int RR     = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_req_encoder_if.slave bus
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] pending_r;
    logic [W-1:0] ptr_r;
    logic [W-1:0] y_r;
    logic         gs_r;
    logic         eout_r;

    logic         grant_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] pending_nx_s;
    logic [W-1:0] ptr_nx_s;
    logic [W-1:0] sel_s;
    logic         any_s;

    // One-hot mask of an index; bits at or above N simply do not exist.
    function automatic logic [N-1:0] onehot_f(input logic [W-1:0] idx);
        logic [N-1:0] m;
        m = '0;
        for (int j = 0; j < N; j++) begin
            m[j] = (idx == W'(j));
        end
        return m;
    endfunction

    // Fixed priority: the highest set index wins (later hits overwrite).
    function automatic logic [W-1:0] pick_fixed_f(input logic [N-1:0] req);
        logic [W-1:0] win;
        win = '0;
        for (int j = 0; j < N; j++) begin
            win = req[j] ? W'(j) : win;
        end
        return win;
    endfunction

    // Round-robin: search last-1, last-2, ... wrapping modulo N, so index
    // 'last' is examined at the very end. Wraps over 0..N-1 only, which
    // keeps non-power-of-two N from ever producing an index >= N.
    function automatic logic [W-1:0] pick_rr_f(input logic [N-1:0] req,
                                               input logic [W-1:0] last);
        logic [W-1:0] win;
        logic         found;
        logic         take;
        int           idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(last) + N - k) % N;
            take  = ~found & req[idx];
            win   = take ? W'(idx) : win;
            found = found | take;
        end
        return win;
    endfunction

    // Next-state: grant/retire, pending update, pointer and winner selection.
    always_comb begin
        grant_s      = gs_r & bus.ack & bus.ein;
        clr_s        = '0;
        pending_nx_s = '0;
        ptr_nx_s     = ptr_r;
        sel_s        = '0;

        if (grant_s) begin
            clr_s = onehot_f(y_r);
        end else begin
            clr_s = '0;
        end

        // New requests are OR-ed in after the clear, so a request
        // re-asserted on its own grant edge stays pending.
        if (STICKY != 0) begin
            pending_nx_s = (pending_r & ~clr_s) | bus.i;
        end else begin
            pending_nx_s = bus.i;
        end

        if ((RR != 0) && grant_s) begin
            ptr_nx_s = y_r;
        end else begin
            ptr_nx_s = ptr_r;
        end

        if (RR != 0) begin
            sel_s = pick_rr_f(pending_nx_s, ptr_nx_s);
        end else begin
            sel_s = pick_fixed_f(pending_nx_s);
        end

        any_s = |pending_nx_s;
    end

    // State and registered outputs; ein gates outputs but never capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= '0;
            ptr_r     <= '0;
            y_r       <= '0;
            gs_r      <= 1'b0;
            eout_r    <= 1'b0;
        end else begin
            pending_r <= pending_nx_s;
            ptr_r     <= ptr_nx_s;
            gs_r      <= bus.ein & any_s;
            eout_r    <= bus.ein & ~any_s;
            y_r       <= (bus.ein & any_s) ? sel_s : '0;
        end
    end

    assign bus.y       = y_r;
    assign bus.gs      = gs_r;
    assign bus.eout    = eout_r;
    assign bus.pending = pending_r;

endmodule

// File: tb/tb_prio_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_prio_req_encoder
// Directed-vector bench for prio_req_encoder. Four instances cover:
//   a : N=8, fixed priority, sticky
//   b : N=8, round-robin, sticky
//   c : N=8, fixed priority, level (non-sticky)
//   d : N=5, round-robin, sticky (non-power-of-two wrap)
// Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_prio_req_encoder;
    logic clk;
    logic rst_n;

    int n_vec;
    int n_miss;

    prio_req_encoder_if #(.N(8)) ifa ();
    prio_req_encoder_if #(.N(8)) ifb ();
    prio_req_encoder_if #(.N(8)) ifc ();
    prio_req_encoder_if #(.N(5)) ifd ();

    prio_req_encoder #(.N(8), .STICKY(1), .RR(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    prio_req_encoder #(.N(8), .STICKY(1), .RR(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    prio_req_encoder #(.N(8), .STICKY(0), .RR(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));
    prio_req_encoder #(.N(5), .STICKY(1), .RR(1)) dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and step just past it to sample.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int ey, input int egs, input int eeo, input int epd);
        check_val({tag, ".y"},    32'(ifa.y),       32'(ey));
        check_val({tag, ".gs"},   32'(ifa.gs),      32'(egs));
        check_val({tag, ".eout"}, 32'(ifa.eout),    32'(eeo));
        check_val({tag, ".pend"}, 32'(ifa.pending), 32'(epd));
    endtask

    // Round-robin grant sequence expected from dut_d with all five requests held.
    int d_exp [7] = '{4, 3, 2, 1, 0, 4, 3};

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        ifa.i = 8'h00; ifa.ein = 1'b0; ifa.ack = 1'b0;
        ifb.i = 8'h00; ifb.ein = 1'b0; ifb.ack = 1'b0;
        ifc.i = 8'h00; ifc.ein = 1'b0; ifc.ack = 1'b0;
        ifd.i = 5'h00; ifd.ein = 1'b0; ifd.ack = 1'b0;

        // ---- reset held with all requests asserted ----
        ifa.i   = 8'hFF;
        ifa.ein = 1'b1;
        tick();
        tick();
        chk_a("rst", 0, 0, 0, 8'h00);

        // ---- release, idle enabled -> eout ----
        rst_n = 1'b1;
        ifa.i = 8'h00;
        tick();
        chk_a("idle", 0, 0, 1, 8'h00);

        // ---- fixed priority, sticky latch ----
        ifa.i = 8'b0010_0100;
        tick();
        chk_a("fix1", 5, 1, 0, 8'h24);
        ifa.i   = 8'h00;
        ifa.ack = 1'b1;
        tick();
        chk_a("fix2", 2, 1, 0, 8'h04);
        tick();
        chk_a("fix3", 0, 0, 1, 8'h00);
        // ack with nothing valid is ignored
        tick();
        chk_a("ackidle", 0, 0, 1, 8'h00);
        ifa.ack = 1'b0;

        // ---- ein gating ----
        ifa.i = 8'h10;
        tick();
        chk_a("ein0", 4, 1, 0, 8'h10);
        ifa.i   = 8'h00;
        ifa.ein = 1'b0;
        ifa.ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_a("einlo", 0, 0, 0, 8'h10);
        end
        ifa.ein = 1'b1;
        ifa.ack = 1'b0;
        tick();
        chk_a("einhi", 4, 1, 0, 8'h10);
        ifa.ack = 1'b1;
        tick();
        chk_a("einret", 0, 0, 1, 8'h00);
        ifa.ack = 1'b0;

        // ---- round-robin fairness, re-asserted bits stay pending ----
        ifb.ein = 1'b1;
        ifb.i   = 8'b1000_0001;
        tick();
        check_val("rr0.y",  32'(ifb.y),  32'd7);
        check_val("rr0.gs", 32'(ifb.gs), 32'd1);
        ifb.ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val("rr.y",    32'(ifb.y),       (k % 2 == 0) ? 32'd0 : 32'd7);
            check_val("rr.pend", 32'(ifb.pending), 32'h81);
            check_val("rr.gs",   32'(ifb.gs),      32'd1);
        end
        ifb.ack = 1'b0;
        ifb.i   = 8'h00;

        // ---- level mode: pending mirrors i, ack clears nothing ----
        ifc.ein = 1'b1;
        ifc.i   = 8'h40;
        tick();
        check_val("lvl1.y",  32'(ifc.y),  32'd6);
        check_val("lvl1.gs", 32'(ifc.gs), 32'd1);
        ifc.i = 8'h00;
        tick();
        check_val("lvl2.gs",   32'(ifc.gs),      32'd0);
        check_val("lvl2.eout", 32'(ifc.eout),    32'd1);
        check_val("lvl2.pend", 32'(ifc.pending), 32'h00);
        ifc.i   = 8'h48;
        ifc.ack = 1'b1;
        tick();
        tick();
        check_val("lvlack.y",    32'(ifc.y),       32'd6);
        check_val("lvlack.pend", 32'(ifc.pending), 32'h48);
        ifc.ack = 1'b0;
        ifc.i   = 8'h00;

        // ---- N=5 round-robin wrap, then asynchronous reset mid-sequence ----
        ifd.ein = 1'b1;
        ifd.ack = 1'b1;
        ifd.i   = 5'b11111;
        for (int k = 0; k < 7; k++) begin
            tick();
            check_val("n5.y",  32'(ifd.y),  32'(d_exp[k]));
            check_val("n5.gs", 32'(ifd.gs), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("n5rst.y",    32'(ifd.y),       32'd0);
        check_val("n5rst.gs",   32'(ifd.gs),      32'd0);
        check_val("n5rst.eout", 32'(ifd.eout),    32'd0);
        check_val("n5rst.pend", 32'(ifd.pending), 32'd0);
        tick();
        rst_n = 1'b1;
        // ptr was cleared by reset, so the search restarts at index 4
        tick();
        check_val("n5post.y", 32'(ifd.y), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/prio_req_encoder.md
# prio_req_encoder

Clocked, parametrised successor to the combinational 4-to-2 priority encoder. It captures N request lines into a pending register and presents the winning index with Ein/GS/Eout cascade semantics. A served request is retired with an Ack handshake. Priority is either fixed (highest index wins) or round-robin. It sits between raw request sources (buttons, interrupt flags) and a consumer that services one index at a time.

## Interface
- N, 8: number of request lines; legal values are N ≥ 2, power of two not required.
- W, $clog2(N): width of Y; derived, never overridden.
- STICKY, 1: 1 = requests latch until acknowledged; 0 = pending mirrors I every cycle.
- RR, 0: 0 = fixed priority, highest index wins; 1 = round-robin.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- I  in  N  request lines, sampled each rising edge.
- Ein  in  1  enable-in; when 0, all outputs are forced inactive.
- Ack  in  1  consumer accepts the current Y; effective only when GS=1.
- Y  out  W  index of the winning pending request; 0 when GS=0.
- GS  out  1  group select / valid: Ein=1 and pending≠0.
- Eout  out  1  enable-out: Ein=1 and pending=0.
- pending  out  N  current pending register, for debug.

## Operation
- State: `pending[N-1:0]` and `ptr[W-1:0]`.
- Outputs Y, GS and Eout are registered.
- grant = GS & Ack & Ein, evaluated on the current registered outputs.
- Next-state rules for `pending`:
  - STICKY=1: pending_nx = (pending & ~onehot(Y) when grant) | I. A request re-asserted on its own grant edge keeps its bit set, because set wins over clear.
  - STICKY=0: pending_nx = I. Ack does not clear anything.
- Ein=0 does not block capture: pending still updates from I. It blocks grants and forces Y=0, GS=0, Eout=0.
- Selection from pending_nx:
  - RR=0: highest set index wins.
  - RR=1: search order is ptr-1, ptr-2, … wrapping modulo N, down to ptr. Index ptr is searched last.
- Round-robin pointer (RR=1):
  - On grant, ptr_nx = Y, so the just-served index becomes lowest priority.
  - Without a grant, ptr holds.
  - RR=0: ptr is unused and stays at 0.
- Registered outputs at each edge:
  - GS = Ein & |pending_nx.
  - Eout = Ein & ~|pending_nx.
  - Y = selected index if GS, else 0.
- Ein=0 forces GS=0 and Eout=0 together. This matches the combinational predecessor, where Eout only signals "enabled and idle".
- Indices at or above N never exist. The search wraps over 0..N-1 only, including when N is not a power of two.

## Timing
- Reset (rst_n=0, asynchronous): pending=0, ptr=0, Y=0, GS=0, Eout=0. Release is synchronous to the next edge.
- Latency: I asserted before edge k gives GS/Y valid after edge k, i.e. 1 cycle.
- Handshake:
  - Ack sampled at edge k with GS=1 retires index Y.
  - After edge k, Y shows the next winner, or GS=0 and Eout=1 if nothing remains.
  - Back-to-back Ack serves one index per cycle.
- Ack while GS=0 is ignored: no state change.
- Ein falling while GS=1: outputs go inactive after the next edge, and no grant occurs on that edge. Pending is retained (STICKY=1). With Ein=1 again, the outputs reappear one cycle later.
- Simultaneous grant of index j and new I[j]=1 (STICKY=1): bit j stays pending. Under RR=1 it drops to lowest priority.
- Reset mid-handshake clears everything immediately. No grant is recorded.

## Test plan
- Reset, RR=0, STICKY=1, N=8: hold rst_n=0 with I=8'hFF → Y=0, GS=0, Eout=0, pending=0. Release, Ein=1, I=0 → Eout=1 after one edge.
- Fixed priority with sticky latch, N=8, RR=0, Ein=1:
  - Pulse I=8'b0010_0100 for one cycle → Y=5, GS=1.
  - Ack one cycle → Y=2.
  - Ack → GS=0, Eout=1, pending=0.
- Round-robin fairness, N=8, RR=1, I held at 8'b1000_0001:
  - Grants alternate: 7, 0, 7, 0 with Ack held high.
  - Every grant edge leaves the re-asserted bit pending.
- Ein gating: pending=8'h10, drop Ein for 3 cycles while pulsing Ack → GS=0, Eout=0, Y=0, pending unchanged at 8'h10. Raise Ein → Y=4, GS=1 one cycle later.
- Level mode, STICKY=0: I=8'h40 for one cycle then 0, no Ack → Y=6, GS=1 for exactly one cycle, then Eout=1.
- Non-power-of-two, N=5, RR=1, W=3, I=5'b11111 held, Ack held → Y cycles 4, 3, 2, 1, 0, 4; Y never exceeds 4. Assert rst_n=0 mid-sequence → all outputs 0 immediately.
